// File: rtl/actuator_matrix_driver.sv
// Row/column H-bridge sequencer for a bistable dot matrix: per column, a SET
// pulse then a CLEAR pulse, each behind an all-off dead window.
module actuator_matrix_driver #(
  parameter int NUM_ROWS = 5,
  parameter int NUM_COLS = 2,
  parameter int CNT_W    = 32
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         enable_n,
  input  logic                         trigger_in_n,
  input  logic [NUM_ROWS*NUM_COLS-1:0] target_state,
  input  logic                         past_state_mode,
  input  logic                         invert,
  input  logic [CNT_W-1:0]             dead_time,
  input  logic [CNT_W-1:0]             pulse_width,
  output logic [NUM_ROWS-1:0]          row_p,
  output logic [NUM_ROWS-1:0]          row_n,
  output logic [NUM_COLS-1:0]          col_p,
  output logic [NUM_COLS-1:0]          col_n,
  output logic                         busy,
  output logic                         trigger_out_n,
  output logic [NUM_ROWS*NUM_COLS-1:0] committed_state
);

  localparam int DOTS  = NUM_ROWS * NUM_COLS;
  localparam int COL_W = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
  localparam int NPH   = 2 * NUM_COLS;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [2:0] {IDLE, LATCH, DEAD_S, SET, DEAD_C, CLEAR, DONE} state_t;

  state_t           state;
  logic [COL_W-1:0] col_idx;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] dead_lim;
  logic [CNT_W-1:0] dead_q;
  logic [CNT_W-1:0] pulse_lim;
  logic [DOTS-1:0]  work_q;
  logic [DOTS-1:0]  mask_q;
  logic             trig_prev;

  logic [DOTS-1:0]     cur_work;
  logic [DOTS-1:0]     cur_mask;
  logic [CNT_W-1:0]    cur_dead;
  logic [NUM_ROWS-1:0] set_rows [NUM_COLS];
  logic [NUM_ROWS-1:0] clr_rows [NUM_COLS];
  logic [NPH-1:0]      ph_active;
  int                  start_ph;
  logic                adv_done;
  logic                adv_clear;
  logic                adv_hazard;
  logic [COL_W-1:0]    adv_col;
  logic                ent_clear;
  logic [COL_W-1:0]    ent_col;
  logic [NUM_ROWS-1:0] drv_row_p;
  logic [NUM_ROWS-1:0] drv_row_n;
  logic [NUM_COLS-1:0] drv_col_p;
  logic [NUM_COLS-1:0] drv_col_n;
  logic                advance;
  logic                dead_end;

  // NOTE: every always_comb output gets a default first, so no path leaves a
  // variable unassigned and no latch is inferred.
  always_comb begin
    // During LATCH the working set comes straight from the inputs so the first
    // phase can be chosen in the same cycle.
    cur_work = (state == LATCH) ? (target_state ^ {DOTS{invert}}) : work_q;
    if (state == LATCH)
      cur_mask = past_state_mode ? (cur_work ^ committed_state) : '1;
    else
      cur_mask = mask_q;
    cur_dead = (state == LATCH) ? dead_time : dead_q;

    for (int c = 0; c < NUM_COLS; c++) begin
      set_rows[c]      =  cur_work[c*NUM_ROWS +: NUM_ROWS] & cur_mask[c*NUM_ROWS +: NUM_ROWS];
      clr_rows[c]      = ~cur_work[c*NUM_ROWS +: NUM_ROWS] & cur_mask[c*NUM_ROWS +: NUM_ROWS];
      ph_active[2*c]   = |set_rows[c];
      ph_active[2*c+1] = |clr_rows[c];
    end

    // Phases are numbered 2*col + (clear ? 1 : 0); empty phases are skipped
    // in zero cycles by searching forward for the next non-empty one.
    case (state)
      SET:     start_ph = 2 * int'(col_idx) + 1;
      CLEAR:   start_ph = 2 * int'(col_idx) + 2;
      default: start_ph = 0;
    endcase
    adv_done  = 1'b1;
    adv_clear = 1'b0;
    adv_col   = '0;
    for (int p = NPH - 1; p >= 0; p--) begin
      if (p >= start_ph && ph_active[p]) begin
        adv_done  = 1'b0;
        adv_clear = p[0];
        adv_col   = COL_W'(p / 2);
      end
    end

    // With no dead time, a row held high in SET must not go straight low in a
    // later column's CLEAR; a single hi-z cycle is forced in that case.
    adv_hazard = (state == SET) && !adv_done && adv_clear && (cur_dead == '0) &&
                 (|(set_rows[col_idx] & clr_rows[adv_col]));

    advance  = (state == LATCH) ||
               (((state == SET) || (state == CLEAR)) && (cnt == pulse_lim - CNT_ONE));
    dead_end = ((state == DEAD_S) || (state == DEAD_C)) && (cnt == dead_lim - CNT_ONE);

    if ((state == DEAD_S) || (state == DEAD_C)) begin
      ent_clear = (state == DEAD_C);
      ent_col   = col_idx;
    end else begin
      ent_clear = adv_clear;
      ent_col   = adv_col;
    end

    drv_row_p = '1;
    drv_row_n = '0;
    drv_col_p = '1;
    drv_col_n = '0;
    if (ent_clear) begin
      drv_col_p[ent_col] = 1'b1;
      drv_col_n[ent_col] = 1'b1;
      drv_row_p          = ~clr_rows[ent_col];
    end else begin
      drv_col_p[ent_col] = 1'b0;
      drv_col_n[ent_col] = 1'b0;
      drv_row_n          = set_rows[ent_col];
    end
  end

  // NOTE: state and outputs use non-blocking assignments only, so every read
  // in this block sees the value from before the clock edge.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state           <= IDLE;
      col_idx         <= '0;
      cnt             <= '0;
      dead_lim        <= '0;
      pulse_lim       <= '0;
      trig_prev       <= 1'b1;
      row_p           <= '1;
      row_n           <= '0;
      col_p           <= '1;
      col_n           <= '0;
      busy            <= 1'b0;
      trigger_out_n   <= 1'b1;
      committed_state <= '0;
      // NOTE: work_q, mask_q and dead_q are always loaded in LATCH before any
      // use, so they carry no reset.
    end else begin
      trig_prev <= trigger_in_n;
      if (state != IDLE && enable_n) begin
        state         <= IDLE;
        cnt           <= '0;
        row_p         <= '1;
        row_n         <= '0;
        col_p         <= '1;
        col_n         <= '0;
        busy          <= 1'b0;
        trigger_out_n <= 1'b1;
      end else if (state == IDLE) begin
        if (!enable_n && trig_prev && !trigger_in_n) begin
          state <= LATCH;
          busy  <= 1'b1;
        end
      end else if (state == DONE) begin
        state         <= IDLE;
        busy          <= 1'b0;
        trigger_out_n <= 1'b1;
      end else begin
        if (state == LATCH) begin
          work_q    <= cur_work;
          mask_q    <= cur_mask;
          dead_q    <= dead_time;
          pulse_lim <= (pulse_width == '0) ? CNT_ONE : pulse_width;
        end

        if (advance) begin
          cnt <= '0;
          if (adv_done) begin
            state           <= DONE;
            trigger_out_n   <= 1'b0;
            committed_state <= cur_work;
            row_p           <= '1;
            row_n           <= '0;
            col_p           <= '1;
            col_n           <= '0;
          end else begin
            col_idx <= adv_col;
            if (cur_dead != '0 || adv_hazard) begin
              state    <= adv_clear ? DEAD_C : DEAD_S;
              dead_lim <= (cur_dead == '0) ? CNT_ONE : cur_dead;
              row_p    <= '1;
              row_n    <= '0;
              col_p    <= '1;
              col_n    <= '0;
            end else begin
              state <= adv_clear ? CLEAR : SET;
              row_p <= drv_row_p;
              row_n <= drv_row_n;
              col_p <= drv_col_p;
              col_n <= drv_col_n;
            end
          end
        end else if (dead_end) begin
          cnt   <= '0;
          state <= (state == DEAD_C) ? CLEAR : SET;
          row_p <= drv_row_p;
          row_n <= drv_row_n;
          col_p <= drv_col_p;
          col_n <= drv_col_n;
        end else begin
          // Bounded by the phase limit, which never exceeds the counter range.
          cnt <= cnt + CNT_ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_actuator_matrix_driver.sv
// Scoreboard bench for actuator_matrix_driver: expected drive phases and
// completions are queued by the stimulus and matched by a negedge monitor.
module tb_actuator_matrix_driver;

  localparam int NR    = 5;
  localparam int NC    = 2;
  localparam int DOTS  = NR * NC;
  localparam int PW    = 2 * (NR + NC);
  localparam int CNT_W = 32;

  logic             clock;
  logic             reset_n;
  logic             enable_n;
  logic             trigger_in_n;
  logic [DOTS-1:0]  target_state;
  logic             past_state_mode;
  logic             invert;
  logic [CNT_W-1:0] dead_time;
  logic [CNT_W-1:0] pulse_width;
  logic [NR-1:0]    row_p, row_n;
  logic [NC-1:0]    col_p, col_n;
  logic             busy;
  logic             trigger_out_n;
  logic [DOTS-1:0]  committed_state;

  actuator_matrix_driver #(.NUM_ROWS(NR), .NUM_COLS(NC), .CNT_W(CNT_W)) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .enable_n        (enable_n),
    .trigger_in_n    (trigger_in_n),
    .target_state    (target_state),
    .past_state_mode (past_state_mode),
    .invert          (invert),
    .dead_time       (dead_time),
    .pulse_width     (pulse_width),
    .row_p           (row_p),
    .row_n           (row_n),
    .col_p           (col_p),
    .col_n           (col_n),
    .busy            (busy),
    .trigger_out_n   (trigger_out_n),
    .committed_state (committed_state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef enum int {EV_NONE, EV_DRIVE, EV_DONE, EV_ABORT} ev_kind_t;
  typedef struct {
    ev_kind_t        kind;
    logic [PW-1:0]   pat;
    int              len;
    int              gap;
    logic [DOTS-1:0] committed;
    int              busy_len;
  } ev_t;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  int  illegal  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [PW-1:0] mk_pat(input bit clr, input int col, input logic [NR-1:0] rows);
    logic [NR-1:0] rp, rn;
    logic [NC-1:0] cp, cn;
    rp = '1; rn = '0; cp = '1; cn = '0;
    if (clr) begin
      cp[col] = 1'b1; cn[col] = 1'b1; rp = ~rows;
    end else begin
      cp[col] = 1'b0; cn[col] = 1'b0; rn = rows;
    end
    return {rp, rn, cp, cn};
  endfunction

  task automatic exp_drive(input bit clr, input int col, input logic [NR-1:0] rows,
                           input int len, input int gap);
    ev_t e;
    e.kind = EV_DRIVE; e.pat = mk_pat(clr, col, rows); e.len = len; e.gap = gap;
    e.committed = '0; e.busy_len = 0;
    exp_q.push_back(e);
  endtask

  task automatic exp_end(input ev_kind_t kind, input logic [DOTS-1:0] committed, input int blen);
    ev_t e;
    e.kind = kind; e.pat = '0; e.len = 0; e.gap = 0;
    e.committed = committed; e.busy_len = blen;
    exp_q.push_back(e);
  endtask

  task automatic pop_exp(output ev_t e);
    if (exp_q.size() == 0) begin
      e.kind = EV_NONE; e.pat = '0; e.len = 0; e.gap = 0; e.committed = '0; e.busy_len = 0;
    end else begin
      e = exp_q.pop_front();
    end
  endtask

  // Monitor state
  logic [PW-1:0] hiz_pat = {{NR{1'b1}}, {NR{1'b0}}, {NC{1'b1}}, {NC{1'b0}}};
  logic [PW-1:0] cur_pat;
  logic [NR-1:0] prev_rp = '1, prev_rn = '0;
  logic [NC-1:0] prev_cp = '1, prev_cn = '0;
  bit            in_drive  = 0;
  bit            prev_busy = 0;
  bit            saw_done  = 0;
  int            run_len   = 0;
  int            cur_gap   = 0;
  int            gap       = 0;
  int            busy_len  = 0;

  task automatic emit_drive();
    ev_t e;
    pop_exp(e);
    check("event kind (drive)", 64'(EV_DRIVE), 64'(e.kind));
    if (e.kind == EV_DRIVE) begin
      check("drive pattern", 64'(cur_pat), 64'(e.pat));
      check("drive length", 64'(run_len), 64'(e.len));
      check("hi-z gap before drive", 64'(cur_gap), 64'(e.gap));
    end
  endtask

  task automatic emit_end(input ev_kind_t kind);
    ev_t e;
    pop_exp(e);
    check("event kind (end)", 64'(kind), 64'(e.kind));
    if (e.kind == kind) begin
      check("committed_state", 64'(committed_state), 64'(e.committed));
      check("busy cycles", 64'(busy_len), 64'(e.busy_len));
    end
  endtask

  always @(negedge clock) begin
    logic [PW-1:0] pat;
    pat = {row_p, row_n, col_p, col_n};
    if ((|(~row_p & row_n)) || (|(~col_p & col_n))) illegal++;
    if ((|(prev_rp & prev_rn & ~row_p & ~row_n)) || (|(prev_cp & prev_cn & ~col_p & ~col_n)))
      illegal++;
    if (busy) busy_len++;
    if (pat != hiz_pat) begin
      if (in_drive && pat == cur_pat) begin
        run_len++;
      end else begin
        if (in_drive) emit_drive();
        in_drive = 1; cur_pat = pat; run_len = 1; cur_gap = gap; gap = 0;
      end
    end else begin
      if (in_drive) begin
        emit_drive();
        in_drive = 0;
      end
      if (busy) gap++;
    end
    if (!trigger_out_n) begin
      emit_end(EV_DONE);
      saw_done = 1;
    end
    if (prev_busy && !busy) begin
      if (!saw_done) emit_end(EV_ABORT);
      busy_len = 0; saw_done = 0; gap = 0;
    end
    prev_busy = busy;
    prev_rp = row_p; prev_rn = row_n; prev_cp = col_p; prev_cn = col_n;
  end

  task automatic check_reset(input string tag);
    check({tag, " row_p"}, 64'(row_p), 64'({NR{1'b1}}));
    check({tag, " row_n"}, 64'(row_n), 64'(0));
    check({tag, " col_p"}, 64'(col_p), 64'({NC{1'b1}}));
    check({tag, " col_n"}, 64'(col_n), 64'(0));
    check({tag, " busy"}, 64'(busy), 64'(0));
    check({tag, " trigger_out_n"}, 64'(trigger_out_n), 64'(1));
    check({tag, " committed_state"}, 64'(committed_state), 64'(0));
  endtask

  // Called at a negedge; returns one negedge later with the request released.
  task automatic pulse_trigger();
    trigger_in_n = 1'b0;
    @(negedge clock);
    trigger_in_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0; enable_n = 1'b0; trigger_in_n = 1'b1;
    target_state = '0; past_state_mode = 1'b0; invert = 1'b0;
    dead_time = 4; pulse_width = 15;
    repeat (3) @(negedge clock);
    check_reset("initial reset");
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    // Single dot in column 0, full drive
    target_state = 10'h001;
    exp_drive(0, 0, 5'b00001, 15, 5);
    exp_drive(1, 0, 5'b11110, 15, 4);
    exp_drive(1, 1, 5'b11111, 15, 4);
    exp_end(EV_DONE, 10'h001, 59);
    pulse_trigger();
    repeat (70) @(negedge clock);

    // Past-state mode: only the changed dot is driven
    target_state = 10'h003; past_state_mode = 1'b1;
    exp_drive(0, 0, 5'b00010, 15, 5);
    exp_end(EV_DONE, 10'h003, 21);
    pulse_trigger();
    repeat (30) @(negedge clock);

    // Enable dropped mid-SET, plus an ignored second request
    target_state = 10'h3FF; past_state_mode = 1'b0;
    exp_drive(0, 0, 5'b11111, 5, 5);
    exp_end(EV_ABORT, 10'h003, 10);
    pulse_trigger();
    repeat (6) @(negedge clock);
    trigger_in_n = 1'b0;
    @(negedge clock);
    trigger_in_n = 1'b1;
    repeat (2) @(negedge clock);
    enable_n = 1'b1;
    repeat (2) @(negedge clock);
    enable_n = 1'b0;
    repeat (30) @(negedge clock);

    // Reset asserted mid-CLEAR
    target_state = 10'h000;
    exp_drive(1, 0, 5'b11111, 3, 5);
    exp_end(EV_ABORT, 10'h000, 8);
    pulse_trigger();
    repeat (7) @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    check_reset("mid-clear reset");
    reset_n = 1'b1;
    repeat (3) @(negedge clock);

    // Inverted all-ones target behaves as all zeros
    target_state = 10'h3FF; invert = 1'b1;
    exp_drive(1, 0, 5'b11111, 15, 5);
    exp_drive(1, 1, 5'b11111, 15, 4);
    exp_end(EV_DONE, 10'h000, 40);
    pulse_trigger();
    repeat (50) @(negedge clock);

    // Zero dead time and zero pulse width: one cycle per executed phase
    invert = 1'b0; dead_time = 0; pulse_width = 0;
    target_state = 10'h022;
    exp_drive(0, 0, 5'b00010, 1, 1);
    exp_drive(1, 0, 5'b11101, 1, 0);
    exp_drive(0, 1, 5'b00001, 1, 0);
    exp_drive(1, 1, 5'b11110, 1, 0);
    exp_end(EV_DONE, 10'h022, 6);
    pulse_trigger();
    repeat (15) @(negedge clock);

    check("scoreboard entries left", 64'(exp_q.size()), 64'(0));
    check("illegal bridge transitions", 64'(illegal), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
